// File: rtl/temp_monitor_seq.sv
// Sequential temperature monitor: averages enabled sensor readings with an
// iterative restoring divider and drives a thermometer LED bar plus alert.
module temp_monitor_seq #(
    parameter int S_NR       = 8,
    parameter int TEMP_WIDTH = 5,
    parameter int T_MIN      = 19,
    parameter int T_MAX      = 26,
    localparam int SUM_W     = TEMP_WIDTH + $clog2(S_NR + 1),
    localparam int LED_W     = T_MAX - T_MIN + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [S_NR*TEMP_WIDTH-1:0] value,
    input  logic [S_NR-1:0]            enable,
    output logic                       busy,
    output logic                       done,
    output logic [TEMP_WIDTH-1:0]      avg_q,
    output logic [SUM_W-1:0]           avg_r,
    output logic [LED_W-1:0]           led_output,
    output logic                       alert,
    output logic                       no_sensor
);

    // state | meaning
    // IDLE  | waiting for start; inputs captured on accept
    // ACCUM | one sensor per cycle summed into acc, enabled count in n
    // DIV   | restoring division acc / n, one quotient bit per cycle
    // DONE  | one-cycle done pulse; results already registered

    localparam int N_W   = $clog2(S_NR + 1);
    localparam int STEPS = (S_NR > SUM_W) ? S_NR : SUM_W;
    localparam int TMR_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_t;

    state_t                     state, state_next;
    logic [S_NR*TEMP_WIDTH-1:0] value_r;
    logic [S_NR-1:0]            enable_r;
    logic [SUM_W-1:0]           acc;
    logic [SUM_W-1:0]           rem;
    logic [N_W-1:0]             n;
    logic [TMR_W-1:0]           tmr;

    logic                       tc;
    logic [N_W-1:0]             n_next;
    logic [SUM_W-1:0]           acc_add;
    logic [SUM_W:0]             trial;
    logic                       ge;
    logic [SUM_W-1:0]           rem_next;
    logic [SUM_W-1:0]           quo_next;
    logic [LED_W-1:0]           led_calc;
    logic                       range_alert;
    logic                       load_div;
    logic                       load_zero;

    assign tc      = (tmr == '0);
    assign n_next  = n + N_W'(enable_r[0]);
    assign acc_add = acc + SUM_W'(value_r[TEMP_WIDTH-1:0]);

    // acc doubles as dividend shifter and quotient collector during DIV
    assign trial    = {rem, acc[SUM_W-1]};
    assign ge       = (trial >= (SUM_W+1)'(n));
    assign rem_next = ge ? (trial[SUM_W-1:0] - SUM_W'(n)) : trial[SUM_W-1:0];
    assign quo_next = {acc[SUM_W-2:0], ge};

    assign load_div  = (state == DIV) && tc;
    assign load_zero = (state == ACCUM) && tc && (n_next == '0);

    always_comb begin
        int a;
        a = int'(quo_next[TEMP_WIDTH-1:0]);
        led_calc = '0;
        for (int k = 0; k < LED_W; k++) begin
            led_calc[k] = (a >= T_MIN + k);
        end
        range_alert = (a < T_MIN) || (a > T_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (tc) state_next = (n_next == '0) ? DONE : DIV;
            DIV:     if (tc) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r  <= '0;
            enable_r <= '0;
            acc      <= '0;
            rem      <= '0;
            n        <= '0;
            tmr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        value_r  <= value;
                        enable_r <= enable;
                        acc      <= '0;
                        rem      <= '0;
                        n        <= '0;
                        tmr      <= TMR_W'(S_NR - 1);
                    end
                end
                ACCUM: begin
                    value_r  <= value_r >> TEMP_WIDTH;
                    enable_r <= enable_r >> 1;
                    n        <= n_next;
                    if (enable_r[0]) acc <= acc_add;
                    if (tc) begin
                        tmr <= TMR_W'(SUM_W - 1);
                        rem <= '0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                DIV: begin
                    acc <= quo_next;
                    rem <= rem_next;
                    if (!tc) tmr <= tmr - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_q      <= '0;
            avg_r      <= '0;
            led_output <= '0;
            alert      <= 1'b0;
            no_sensor  <= 1'b0;
        end else if (load_div) begin
            avg_q      <= quo_next[TEMP_WIDTH-1:0];
            avg_r      <= rem_next;
            led_output <= led_calc;
            alert      <= range_alert;
            no_sensor  <= 1'b0;
        end else if (load_zero) begin
            avg_q      <= '0;
            avg_r      <= '0;
            led_output <= '0;
            alert      <= 1'b1;
            no_sensor  <= 1'b1;
        end
    end

endmodule
